// File: rtl/sigma_delta_pkg.sv
// rtl/sigma_delta_pkg.sv - shared widths, feedback constants and saturation helpers for the sigma-delta DAC
//
// No ports. Provides:
//   sd_order_e       legal modulator orders
//   wide_t           wide signed scratch type used for saturation arithmetic
//   acc_width()      integrator width from sample width and guard bits
//   order_is_legal() elaboration check for the ORDER parameter
//   fb_value()       +/-2^(WIDTH-1) feedback for the current output bit
//   sat_clamp()      clamp a wide value into the AW-bit two's complement range
//   sat_hit()        true when sat_clamp() would change the value
package sigma_delta_pkg;

    localparam int MAX_AW = 64;

    typedef enum int {
        SD_ORDER_FIRST  = 1,
        SD_ORDER_SECOND = 2
    } sd_order_e;

    typedef logic signed [MAX_AW-1:0] wide_t;

    function automatic int acc_width(input int width, input int guard);
        return width + guard;
    endfunction

    function automatic bit order_is_legal(input int order);
        return (order == int'(SD_ORDER_FIRST)) || (order == int'(SD_ORDER_SECOND));
    endfunction

    // Full-scale feedback: a 1 on the output represents +2^(WIDTH-1), a 0 represents -2^(WIDTH-1).
    function automatic wide_t fb_value(input int width, input logic dac);
        wide_t mag;
        mag = wide_t'(1) <<< (width - 1);
        return dac ? mag : -mag;
    endfunction

    function automatic wide_t sat_hi(input int aw);
        return (wide_t'(1) <<< (aw - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_lo(input int aw);
        return -(wide_t'(1) <<< (aw - 1));
    endfunction

    function automatic wide_t sat_clamp(input wide_t v, input int aw);
        wide_t hi;
        wide_t lo;
        hi = sat_hi(aw);
        lo = sat_lo(aw);
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic sat_hit(input wide_t v, input int aw);
        return (v > sat_hi(aw)) || (v < sat_lo(aw));
    endfunction

endpackage

// File: rtl/sd_integrator.sv
// rtl/sd_integrator.sv - one saturating integrator stage of the sigma-delta modulator
//
// Ports:
//   clk       clock, rising edge
//   res       synchronous active-high reset, clears the accumulator
//   en        update strobe (modulator tick)
//   addend    AW-bit two's complement input added this update
//   fb_pos    current output bit; selects +/-2^(WIDTH-1) feedback to subtract
//   acc_next  clamped value the accumulator takes on the next enabled edge
//   sat       the clamp is active for the current inputs
module sd_integrator
    import sigma_delta_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = 20
) (
    input  logic          clk,
    input  logic          res,
    input  logic          en,
    input  logic [AW-1:0] addend,
    input  logic          fb_pos,
    output logic [AW-1:0] acc_next,
    output logic          sat
);

    // Two headroom bits: acc + addend - fb cannot overflow before clamping.
    localparam int SW = AW + 2;

    logic [AW-1:0]        acc;
    logic signed [SW-1:0] sum;
    wide_t                wide;

    always_comb begin
        sum      = SW'(signed'(acc)) + SW'(signed'(addend)) - SW'(fb_value(WIDTH, fb_pos));
        wide     = wide_t'(sum);
        acc_next = AW'(sat_clamp(wide, AW));
        sat      = sat_hit(wide, AW);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/sigma_delta_dac.sv
// rtl/sigma_delta_dac.sv - parametrised 1st/2nd order sigma-delta DAC modulator with sample handshake
//
// Ports:
//   i_clk           clock, rising edge
//   i_res           synchronous active-high reset
//   i_enable        clock-enable for the rate divider and the modulator
//   i_sample        signed WIDTH-bit PCM sample
//   i_valid         i_sample is valid
//   o_ready         pending buffer empty; sample taken when i_valid && o_ready
//   i_clr_overload  clears o_overload (a new saturation in the same cycle wins)
//   o_DAC           registered pulse-density output
//   o_overload      sticky: an integrator saturated
module sigma_delta_dac
    import sigma_delta_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_GUARD = 4,
    parameter int ORDER     = 2,
    parameter int OSR_DIV   = 1
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_sample,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_clr_overload,
    output logic             o_DAC,
    output logic             o_overload
);

    localparam int AW = acc_width(WIDTH, ACC_GUARD);
    localparam int CW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

    if (!order_is_legal(ORDER)) begin : g_bad_order
        $error("sigma_delta_dac: ORDER must be 1 or 2");
    end
    if (OSR_DIV < 1) begin : g_bad_osr
        $error("sigma_delta_dac: OSR_DIV must be at least 1");
    end

    logic [CW-1:0]    cnt;
    logic             tick;
    logic             pend_full;
    logic [WIDTH-1:0] pend_val;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] x;
    logic [AW-1:0]    x_ext;
    logic             take;
    logic [AW-1:0]    stage_next [ORDER];
    logic [ORDER-1:0] stage_sat;

    assign tick    = i_enable && (cnt == CW'(OSR_DIV - 1));
    assign o_ready = ~pend_full;
    assign take    = i_valid && ~pend_full;

    // A full pending slot is consumed by the tick; otherwise the last sample is held.
    assign x     = pend_full ? pend_val : active;
    assign x_ext = AW'(signed'(x));

    for (genvar k = 0; k < ORDER; k++) begin : g_stage
        logic [AW-1:0] addend;
        if (k == 0) begin : g_first
            assign addend = x_ext;
        end else begin : g_chain
            assign addend = stage_next[k-1];
        end

        sd_integrator #(
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_integrator (
            .clk      (i_clk),
            .res      (i_res),
            .en       (tick),
            .addend   (addend),
            .fb_pos   (o_DAC),
            .acc_next (stage_next[k]),
            .sat      (stage_sat[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            cnt        <= '0;
            pend_full  <= 1'b0;
            pend_val   <= '0;
            active     <= '0;
            o_DAC      <= 1'b0;
            o_overload <= 1'b0;
        end else begin
            if (i_enable) begin
                cnt <= tick ? '0 : cnt + CW'(1);
            end

            if (tick && pend_full) begin
                active <= pend_val;
            end

            // take only happens with the slot empty, so it never races the tick's consume.
            if (take) begin
                pend_full <= 1'b1;
                pend_val  <= i_sample;
            end else if (tick) begin
                pend_full <= 1'b0;
            end

            if (tick) begin
                o_DAC <= ~stage_next[ORDER-1][AW-1];
            end

            if (tick && (|stage_sat)) begin
                o_overload <= 1'b1;
            end else if (i_clr_overload) begin
                o_overload <= 1'b0;
            end
        end
    end

endmodule
